// File: rtl/burst_arbiter.sv
// rtl/burst_arbiter.sv - shares one word consumer between NUM_REQ FIFOs in fixed-length bursts
// Define BURST_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module burst_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4,
    parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_empty_n,
    output logic [NUM_REQ-1:0]            req_deq,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_empty_n,
    input  logic                          out_deq,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy,
    output logic                          burst_done
);

    localparam int CNT_WIDTH = $clog2(BURST_LEN + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BURST_LEN - 1);
    localparam logic [ID_WIDTH-1:0]  LAST_ID  = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [CNT_WIDTH-1:0]   count, count_nxt;
    logic [ID_WIDTH-1:0]    grant_nxt;
    logic                   done_nxt;
    logic [ID_WIDTH-1:0]    win_id;
    logic                   win_found;
    logic                   transfer;

`ifdef BURST_ARB_FIXED_PRIO_EN
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_empty_n[i]) begin
                win_found = 1'b1;
                win_id    = ID_WIDTH'(i);
            end
        end
    end
`else
    logic [ID_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
    int                  idx;

    // Search starts at rr_ptr and wraps, so the last-served requester goes to the back.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_found && req_empty_n[idx]) begin
                win_found = 1'b1;
                win_id    = ID_WIDTH'(idx);
            end
        end
    end
`endif

    // Datapath is a pure mux on the held grant: no added latency while bursting.
    always_comb begin
        out_data    = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        out_empty_n = (state == BURST) && req_empty_n[grant_id];
        transfer    = out_deq && out_empty_n;
        req_deq     = '0;
        if (transfer) begin
            req_deq[grant_id] = 1'b1;
        end
        busy = (state == BURST);
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        grant_nxt  = grant_id;
        done_nxt   = 1'b0;
`ifndef BURST_ARB_FIXED_PRIO_EN
        rr_ptr_nxt = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt = BURST;
                    grant_nxt = win_id;
                    count_nxt = '0;
                end
            end
            BURST: begin
                if (transfer) begin
                    if (count == LAST_CNT) begin
                        state_nxt  = IDLE;
                        count_nxt  = '0;
                        done_nxt   = 1'b1;
`ifndef BURST_ARB_FIXED_PRIO_EN
                        rr_ptr_nxt = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
`endif
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            grant_id   <= '0;
            burst_done <= 1'b0;
`ifndef BURST_ARB_FIXED_PRIO_EN
            rr_ptr     <= '0;
`endif
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            grant_id   <= grant_nxt;
            burst_done <= done_nxt;
`ifndef BURST_ARB_FIXED_PRIO_EN
            rr_ptr     <= rr_ptr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_burst_arbiter.sv
// tb/tb_burst_arbiter.sv - scoreboard bench for burst_arbiter with modelled producer FIFOs
module tb_burst_arbiter;

    localparam int DW = 16;
    localparam int NR = 4;
    localparam int BL = 4;

    logic              clk;
    logic              rst_n;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_empty_n;
    logic [NR-1:0]     req_deq;
    logic [DW-1:0]     out_data;
    logic              out_empty_n;
    logic              out_deq;
    logic [1:0]        grant_id;
    logic              busy;
    logic              burst_done;

    burst_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_data    (req_data),
        .req_empty_n (req_empty_n),
        .req_deq     (req_deq),
        .out_data    (out_data),
        .out_empty_n (out_empty_n),
        .out_deq     (out_deq),
        .grant_id    (grant_id),
        .busy        (busy),
        .burst_done  (burst_done)
    );

    typedef struct {
        int          id;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          wc = 0;
    bit          exp_done = 0;
    int          ptr[NR];
    int          len[NR];
    logic [15:0] base[NR];
    bit          en[NR];
    bit          sink_rdy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every accepted word is matched against the scoreboard, including its cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            wc       = 0;
            exp_done = 0;
        end else begin
            chk("burst_done", 32'(burst_done), 32'(exp_done));
            if (burst_done) done_cnt++;
            if (exp_done) begin
                chk("bubble_busy", 32'(busy), 32'd0);
                chk("bubble_valid", 32'(out_empty_n), 32'd0);
            end
            exp_done = 0;
            if (out_empty_n && out_deq) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_id", 32'(grant_id), 32'(e.id));
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("req_deq", 32'(req_deq), 32'(1 << e.id));
                    chk("word_cycle", 32'(cyc), 32'(e.cyc));
                    wc++;
                    if (wc == BL) begin
                        wc       = 0;
                        exp_done = 1;
                    end
                end
            end else begin
                chk("idle_req_deq", 32'(req_deq), 32'd0);
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_empty_n[i]         = en[i] && (ptr[i] < len[i]);
            req_data[i*DW +: DW]   = base[i] + 16'(ptr[i]);
        end
        out_deq = sink_rdy;
    endtask

    task automatic clear_src();
        for (int i = 0; i < NR; i++) begin
            ptr[i]  = 0;
            len[i]  = 0;
            base[i] = 16'h0;
            en[i]   = 1'b1;
        end
        sink_rdy = 1'b1;
    endtask

    // mode 1: starved grant 1; mode 2: backpressured word held
    task automatic cycle(input int mode, input logic [15:0] expw);
        logic [NR-1:0] d;
        @(negedge clk);
        if (mode == 1) begin
            chk("starve_valid", 32'(out_empty_n), 32'd0);
            chk("starve_busy", 32'(busy), 32'd1);
            chk("starve_grant", 32'(grant_id), 32'd1);
        end else if (mode == 2) begin
            chk("hold_valid", 32'(out_empty_n), 32'd1);
            chk("hold_data", 32'(out_data), 32'(expw));
            chk("hold_busy", 32'(busy), 32'd1);
        end
        d = req_deq;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (d[i]) ptr[i]++;
        drive();
    endtask

    task automatic push_word(input int id, input int p, input int c);
        exp_t x;
        x.id   = id;
        x.data = base[id] + 16'(p);
        x.cyc  = c;
        exp_q.push_back(x);
    endtask

    task automatic push_burst(input int id, input int p, input int c);
        for (int w = 0; w < BL; w++) push_word(id, p + w, c + w);
    endtask

    task automatic reset_checks();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(burst_done), 32'd0);
        chk("rst_valid", 32'(out_empty_n), 32'd0);
        chk("rst_req_deq", 32'(req_deq), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        reset_checks();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle(0, 16'h0);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (2) cycle(0, 16'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        int c0;
        int d0;
        int used[NR];
        int ord2[8];
        int ord6[4];
`ifdef BURST_ARB_FIXED_PRIO_EN
        ord2 = '{0, 0, 1, 1, 2, 2, 3, 3};
        ord6 = '{0, 0, 3, 3};
`else
        ord2 = '{0, 1, 2, 3, 0, 1, 2, 3};
        ord6 = '{0, 3, 0, 3};
`endif
        rst_n = 1'b1;
        clear_src();
        for (int i = 0; i < NR; i++) len[i] = 1;
        drive();
        #2;
        do_reset();

        // single requester 2
        clear_src();
        len[2]  = 4;
        base[2] = 16'h00A0;
        drive();
        c0 = cyc;
        d0 = done_cnt;
        push_burst(2, 0, c0 + 1);
        drain(50);
        @(negedge clk);
        chk("t1_done_count", 32'(done_cnt - d0), 32'd1);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_last_grant", 32'(grant_id), 32'd2);

        // all requesters always non-empty
        do_reset();
        clear_src();
        for (int i = 0; i < NR; i++) begin
            len[i]  = 8;
            base[i] = 16'(4096 * (i + 1));
            used[i] = 0;
        end
        drive();
        c0 = cyc;
        d0 = done_cnt;
        for (int k = 0; k < 8; k++) begin
            push_burst(ord2[k], used[ord2[k]], c0 + 1 + 5 * k);
            used[ord2[k]] += BL;
        end
        drain(100);
        chk("t2_done_count", 32'(done_cnt - d0), 32'd8);

        // granted requester 1 runs dry for 3 cycles while 3 waits
        do_reset();
        clear_src();
        len[1]  = 4;
        len[3]  = 4;
        base[1] = 16'h0B00;
        base[3] = 16'h0D00;
        drive();
        c0 = cyc;
        push_word(1, 0, c0 + 1);
        push_word(1, 1, c0 + 2);
        push_word(1, 2, c0 + 6);
        push_word(1, 3, c0 + 7);
        push_burst(3, 0, c0 + 9);
        repeat (3) cycle(0, 16'h0);
        en[1] = 1'b0;
        drive();
        repeat (3) cycle(1, 16'h0);
        en[1] = 1'b1;
        drive();
        drain(60);

        // downstream backpressure for 5 cycles
        do_reset();
        clear_src();
        len[0]  = 4;
        base[0] = 16'h0E00;
        drive();
        c0 = cyc;
        push_word(0, 0, c0 + 1);
        push_word(0, 1, c0 + 2);
        push_word(0, 2, c0 + 8);
        push_word(0, 3, c0 + 9);
        repeat (3) cycle(0, 16'h0);
        sink_rdy = 1'b0;
        drive();
        repeat (5) cycle(2, 16'h0E02);
        sink_rdy = 1'b1;
        drive();
        drain(60);

        // async reset at word 2 of the second burst
        do_reset();
        clear_src();
        base[1] = 16'h5100;
        base[3] = 16'h5300;
`ifdef BURST_ARB_FIXED_PRIO_EN
        len[1] = 10;
        len[3] = 4;
`else
        len[1] = 8;
        len[3] = 6;
`endif
        drive();
        c0 = cyc;
        push_burst(1, 0, c0 + 1);
`ifdef BURST_ARB_FIXED_PRIO_EN
        push_word(1, 4, c0 + 6);
        push_word(1, 5, c0 + 7);
`else
        push_word(3, 0, c0 + 6);
        push_word(3, 1, c0 + 7);
`endif
        repeat (8) cycle(0, 16'h0);
        chk("t5_pre_reset_words", 32'(exp_q.size()), 32'd0);
        do_reset();
        c0 = cyc;
`ifdef BURST_ARB_FIXED_PRIO_EN
        push_burst(1, 6, c0 + 1);
        push_burst(3, 0, c0 + 6);
`else
        push_burst(1, 4, c0 + 1);
        push_burst(3, 2, c0 + 6);
`endif
        drain(80);

        // requesters 0 and 3 always non-empty
        do_reset();
        clear_src();
        len[0]  = 8;
        len[3]  = 8;
        base[0] = 16'h6000;
        base[3] = 16'h6300;
        used[0] = 0;
        used[3] = 0;
        drive();
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            push_burst(ord6[k], used[ord6[k]], c0 + 1 + 5 * k);
            used[ord6[k]] += BL;
        end
        drain(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_arbiter.md
# burst_arbiter

Shares one word-stream consumer (the word aggregator ahead of the feature buffer) between NUM_REQ producer FIFOs. Grants one requester at a time and holds the grant for exactly BURST_LEN transferred words, so every aggregated line holds words from a single source. Sits between the per-channel output FIFOs and the aggregator's sender-side dequeue interface. Uses round-robin arbitration between bursts by default.

## Interface
- DATA_WIDTH, 16, word width
- NUM_REQ, 4, number of requesters (≥1)
- BURST_LEN, 4, words per granted burst (≥1); set equal to the aggregator's FETCH_WIDTH
- ID_WIDTH, $clog2(NUM_REQ) (min 1), grant index width
- clk  input  1  clock, all state on posedge
- rst_n  input  1  reset, asynchronous, active-low
- req_data  input  NUM_REQ*DATA_WIDTH  requester i word at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- req_empty_n  input  NUM_REQ  requester i has a word
- req_deq  output  NUM_REQ  dequeue strobe to requester i
- out_data  output  DATA_WIDTH  word to aggregator
- out_empty_n  output  1  word valid to aggregator
- out_deq  input  1  aggregator dequeue
- grant_id  output  ID_WIDTH  index of current/last granted requester
- busy  output  1  high in BURST state
- burst_done  output  1  registered one-cycle pulse after final word of a burst

## Operation
- Transfer = out_deq && out_empty_n in a cycle.
- States: IDLE, BURST.
- IDLE: out_empty_n=0, req_deq=0. If any req_empty_n bit set, register winner into grant_id, clear count, go to BURST. Otherwise stay.
- Round-robin winner: first set bit of req_empty_n searching from rr_ptr upward, wrapping at NUM_REQ-1 → 0.
- BURST: out_data = req_data slice[grant_id]; out_empty_n = req_empty_n[grant_id]; req_deq[grant_id] = out_deq && req_empty_n[grant_id]; all other req_deq bits 0.
- Each transfer increments count (width $clog2(BURST_LEN+1)). On a transfer with count==BURST_LEN-1: go IDLE, rr_ptr ← grant_id+1 (wrap to 0 at NUM_REQ), pulse burst_done next cycle.
- Granted requester running empty mid-burst: grant held, out_empty_n=0, no other requester served until burst completes.
- out_deq while out_empty_n=0: ignored, no count change, no req_deq.
- Requests from non-granted requesters during BURST: ignored until IDLE.
- NUM_REQ=1: always grants 0. BURST_LEN=1: one word per grant.

## Timing
- Reset (async assert): state IDLE, count 0, rr_ptr 0, grant_id 0, busy 0, burst_done 0; req_deq=0 and out_empty_n=0 combinationally.
- Reset mid-burst: burst abandoned, no burst_done; rr_ptr returns to 0.
- Arbitration latency: request seen in IDLE cycle N → out_empty_n can be high in cycle N+1.
- out_data, out_empty_n, req_deq combinational from state and inputs (no added latency in BURST); full-rate one word per cycle.
- Burst end → IDLE costs one bubble cycle before next grant's first word (max throughput BURST_LEN words per BURST_LEN+1 cycles).
- burst_done high in the cycle after the final transfer, concurrent with IDLE.

## Configuration
- BURST_ARB_FIXED_PRIO_EN defined: fixed priority, lowest-index requester with req_empty_n set wins every IDLE decision; rr_ptr not implemented.
- Undefined (default): round-robin as above.

## Test plan
- Single requester: reset, req_empty_n=4'b0100 with words 0xA0..0xA3, out_deq tied to out_empty_n → grant_id=2, four transfers, req_deq[2] pulses 4 times, burst_done one cycle after 4th, busy low after.
- Round-robin fairness: all four requesters always non-empty, out_deq=1 → grant order 0,1,2,3,0; each burst exactly 4 words; one idle cycle between bursts.
- Mid-burst starvation: grant 1, req_empty_n[1] drops after 2 words for 3 cycles while req 3 stays non-empty → out_empty_n=0 those cycles, req_deq[3] never asserted, burst resumes and completes on requester 1.
- Downstream backpressure: out_deq low for 5 cycles mid-burst → count, req_deq, data held; no words lost or duplicated.
- Async reset at word 2 of burst → outputs return to reset values immediately, next grant after release starts from rr_ptr 0 with count 0.
- With BURST_ARB_FIXED_PRIO_EN: requesters 0 and 3 always non-empty → requester 0 granted every burst, requester 3 never.
